// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word serializer: FSM state encoding,
// default geometry and the slice-counter width helper.
package word_serializer_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A counter for a single slice still needs one bit.
  function automatic int cnt_width(input int num_chunks);
    return ($clog2(num_chunks) < 1) ? 1 : $clog2(num_chunks);
  endfunction

endpackage

// File: rtl/word_serializer_slice_counter.sv
// Modulo-NUM_CHUNKS slice index. clr has priority over inc; is_last flags
// the final slice of a word.
module slice_counter
  import word_serializer_pkg::*;
#(
  parameter int NUM_CHUNKS = DEFAULT_WIDTH / DEFAULT_CHUNK,
  parameter int CNT_W      = cnt_width(NUM_CHUNKS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic is_last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign is_last = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Accepts one WIDTH-bit word and emits it as NUM_CHUNKS CHUNK-bit slices.
// Define WORD_SERIALIZER_MSB_FIRST_EN to emit the most-significant slice first.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || NUM_CHUNKS < 2) begin : g_bad_geometry
    $error("word_serializer: WIDTH must be a multiple of CHUNK with at least 2 slices");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_next;
  logic             cnt_clr, cnt_inc, is_last;

`ifdef WORD_SERIALIZER_MSB_FIRST_EN
  assign out_data   = shift_q[WIDTH-1 -: CHUNK];
  assign shift_next = shift_q << CHUNK;
`else
  assign out_data   = shift_q[CHUNK-1:0];
  assign shift_next = shift_q >> CHUNK;
`endif

  assign busy     = (state_q == SHIFT);
  assign out_last = busy & is_last;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        // Combinational from out_ready so the next word loads with no bubble.
        in_ready  = out_ready & is_last;
        if (out_ready) begin
          if (is_last && in_valid) begin
            shift_d = in_data;
            cnt_clr = 1'b1;
          end else begin
            shift_d = shift_next;
            cnt_inc = 1'b1;
            if (is_last) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  slice_counter #(
    .NUM_CHUNKS(NUM_CHUNKS)
  ) u_slice_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .is_last(is_last)
  );

endmodule
